// File: rtl/io_map_pkg.sv
// io_map_pkg: shared I/O address map and write-select codes.
// Imported by the I/O port bank and by the memory unit controller, so both
// sides decode the I/O window and select codes from one source.
package io_map_pkg;

  localparam logic [9:0] IO_OUT0_ADDR   = 10'h3FF;
  localparam logic [9:0] IO_OUT1_ADDR   = 10'h3FE;
  localparam logic [9:0] IO_STATUS_ADDR = 10'h3FD;

  localparam logic [4:0] SEL_MEM  = 5'd0;
  localparam logic [4:0] SEL_OUT0 = 5'd1;
  localparam logic [4:0] SEL_OUT1 = 5'd2;

  // Register addressed by a read in the I/O window.
  typedef enum logic [1:0] {
    IO_NONE   = 2'd0,
    IO_IN0    = 2'd1,
    IO_IN1    = 2'd2,
    IO_STATUS = 2'd3
  } io_reg_e;

  function automatic io_reg_e io_decode(input logic [9:0] a);
    io_reg_e r;
    r = IO_NONE;
    if (a == IO_OUT0_ADDR)        r = IO_IN0;
    else if (a == IO_OUT1_ADDR)   r = IO_IN1;
    else if (a == IO_STATUS_ADDR) r = IO_STATUS;
    return r;
  endfunction

endpackage

// File: rtl/io_port_bank_if.sv
// io_port_bank_if: load/store bus between the memory unit controller and the
// I/O port bank.
//   master: drives wr_en, rd_en, addr, sel_mux_data_in, wr_data;
//           receives rd_data, rd_hit.
//   slave : the port bank side.
interface io_port_bank_if #(
  parameter int addr_width = 10,
  parameter int data_width = 32
);
  logic                  wr_en;
  logic                  rd_en;
  logic [addr_width-1:0] addr;
  logic [4:0]            sel_mux_data_in;
  logic [data_width-1:0] wr_data;
  logic [data_width-1:0] rd_data;
  logic                  rd_hit;

  modport master (
    output wr_en, rd_en, addr, sel_mux_data_in, wr_data,
    input  rd_data, rd_hit
  );

  modport slave (
    input  wr_en, rd_en, addr, sel_mux_data_in, wr_data,
    output rd_data, rd_hit
  );
endinterface

// File: rtl/io_port_bank_sync2.sv
// io_sync2: width-parameterised two-flop synchroniser, synchronous
// active-high reset.
//   clk, rst : clock and reset
//   d        : asynchronous input
//   q        : synchronised output (two clk edges after d is captured)
module io_sync2 #(
  parameter int width = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [width-1:0] d,
  output logic [width-1:0] q
);

  logic [width-1:0] meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/io_port_bank.sv
// io_port_bank: memory-mapped I/O port bank behind the memory unit controller.
// Owns the two output port registers, synchronises two asynchronous input
// ports, keeps a sticky per-input change flag and returns registered load data
// for the I/O window (0x3FF IN0/OUT0, 0x3FE IN1/OUT1, 0x3FD STATUS).
//   clk, rst              : core clock, synchronous active-high reset
//   bus (slave)           : store/load strobes, address, select code, data
//   in_port0, in_port1    : asynchronous physical inputs
//   out_port0, out_port1  : physical output registers
//   in_changed            : sticky change flags {IN1, IN0}
module io_port_bank
  import io_map_pkg::*;
#(
  parameter int addr_width = 10,
  parameter int data_width = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  io_port_bank_if.slave         bus,
  input  logic [data_width-1:0] in_port0,
  input  logic [data_width-1:0] in_port1,
  output logic [data_width-1:0] out_port0,
  output logic [data_width-1:0] out_port1,
  output logic [1:0]            in_changed
);

  logic [data_width-1:0] in0_s, in1_s;
  logic [data_width-1:0] in0_q, in1_q;
  io_reg_e               io_sel;
  logic                  rd_accept;
  logic [1:0]            set_flag, clr_flag;
  logic [data_width-1:0] rd_mux;

  io_sync2 #(.width(data_width)) u_sync0 (
    .clk (clk), .rst (rst), .d (in_port0), .q (in0_s)
  );

  io_sync2 #(.width(data_width)) u_sync1 (
    .clk (clk), .rst (rst), .d (in_port1), .q (in1_s)
  );

  // The window addresses are the 10-bit constants zero-extended to the bus;
  // a bus narrower than 10 bits cannot reach them, so nothing decodes.
  if (addr_width >= 10) begin : g_decode
    logic upper_zero;
    if (addr_width > 10) begin : g_wide
      assign upper_zero = ~|bus.addr[addr_width-1:10];
    end else begin : g_exact
      assign upper_zero = 1'b1;
    end
    assign io_sel = upper_zero ? io_decode(bus.addr[9:0]) : IO_NONE;
  end else begin : g_no_decode
    assign io_sel = IO_NONE;
  end

  // A store in the same cycle wins; the load is dropped entirely.
  assign rd_accept = bus.rd_en & ~bus.wr_en;

  assign set_flag = {in1_s != in1_q, in0_s != in0_q};
  assign clr_flag = {rd_accept & (io_sel == IO_IN1),
                     rd_accept & (io_sel == IO_IN0)};

  always_comb begin
    rd_mux = '0;
    case (io_sel)
      IO_IN0:    rd_mux = in0_s;
      IO_IN1:    rd_mux = in1_s;
      IO_STATUS: rd_mux = {{(data_width-2){1'b0}}, in_changed};
      default:   rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_port0   <= '0;
      out_port1   <= '0;
      in0_q       <= '0;
      in1_q       <= '0;
      in_changed  <= '0;
      bus.rd_data <= '0;
      bus.rd_hit  <= 1'b0;
    end else begin
      if (bus.wr_en && bus.sel_mux_data_in == SEL_OUT0) out_port0 <= bus.wr_data;
      if (bus.wr_en && bus.sel_mux_data_in == SEL_OUT1) out_port1 <= bus.wr_data;

      in0_q <= in0_s;
      in1_q <= in1_s;

      // Set has priority so an edge arriving during the clearing read is kept.
      in_changed <= set_flag | (in_changed & ~clr_flag);

      if (rd_accept && io_sel != IO_NONE) begin
        bus.rd_hit  <= 1'b1;
        bus.rd_data <= rd_mux;
      end else begin
        bus.rd_hit  <= 1'b0;
        bus.rd_data <= '0;
      end
    end
  end

endmodule
